// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Sequential shift-add multiplier. It adds one partial product per clock, so
//   a 2*WIDTH-bit product is ready WIDTH cycles after the accepting edge. A
//   start/done handshake frames each operation. Back-to-back operation is
//   supported: a start sampled in the DONE state is accepted straight away.
//
//   Optional build macro:
//     SEQ_MUL_SIGNED_EN - operands and product are two's complement. The core
//                         multiplies the operand magnitudes and negates the
//                         result when it writes product. Latency is unchanged.
//
//   Parameters:
//     WIDTH    operand width, 2..16 (default 8)
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset    in   asynchronous active-high reset, clears all state
//     start    in   request, sampled only in IDLE or DONE
//     a        in   multiplicand [WIDTH-1:0], captured on the accepting edge
//     b        in   multiplier   [WIDTH-1:0], captured on the accepting edge
//     busy     out  high while the multiply is in progress (CALC)
//     done     out  one-cycle pulse, product valid from this cycle on
//     product  out  result register [2*WIDTH-1:0], held until next result
// -----------------------------------------------------------------------------
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [PW-1:0]    mcand_q,   mcand_d;
   logic [WIDTH-1:0] mplier_q,  mplier_d;
   logic [PW-1:0]    acc_q,     acc_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [PW-1:0]    product_q, product_d;
   logic             neg_q,     neg_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             neg_in;
   logic [PW-1:0]    sum;
   logic             last;

   // Condition the operands before capture. In the signed build the core only
   // sees magnitudes. -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), and that value is
   // exact when the WIDTH-bit register is read as unsigned.
`ifdef SEQ_MUL_SIGNED_EN
   always_comb begin
      a_mag  = a[WIDTH-1] ? -a : a;
      b_mag  = b[WIDTH-1] ? -b : b;
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
   end
`else
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_in = 1'b0;
   end
`endif

   // Accumulator value after this cycle's partial product.
   assign sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      neg_d     = neg_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = neg_in;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_CALC;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // The final partial sum goes straight into product. This saves a
            // cycle compared with passing it through acc first.
            if (last) begin
               product_d = neg_q ? -sum : sum;
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_CALC);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule
